// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter
// Round-robin arbiter that hands a shared 3-to-8 decoder to one of eight
// requesters at a time. The owner keeps the decoder until it drops its request
// or pulses done. Every release costs one dead cycle, and the search pointer
// moves to the index just past the released owner.
//
// Optional feature: define RR_ARB_TIMEOUT_EN to add a hold counter. The
// counter forces a release after HOLD_MAX consecutive grant cycles and pulses
// timeout. Without the macro, timeout is tied low and HOLD_MAX is only range
// checked.
module decoder_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic       enb,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       timeout
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Reject an illegal hold limit when the design is elaborated.
    if ((HOLD_MAX < 32'd2) || (HOLD_MAX > 32'd255)) begin : g_hold_max_range
        $error("decoder_rr_arbiter: HOLD_MAX must be within 2..255");
    end

    // First set request at or above ptr, wrapping from 7 back to 0.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        logic [2:0] pick;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = p + i[2:0];
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // One-hot decode of an owner index.
    function automatic logic [7:0] dec3to8(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_ptr;
    logic [2:0] w_ptr_nxt;
    logic [2:0] r_sel;
    logic [2:0] w_sel_nxt;
    logic       r_enb;
    logic       w_enb_nxt;
    logic [7:0] r_gnt;
    logic [7:0] w_gnt_nxt;
    logic [2:0] w_pick;
    logic       w_owner_req;
    logic       w_force;
    logic       w_release;

    assign w_pick      = rr_pick(req, r_ptr);
    assign w_owner_req = req[r_sel];

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);

    logic [7:0] r_hold_cnt;
    logic [7:0] w_hold_cnt_nxt;
    logic       r_timeout;

    // Force a release when the owner is still requesting in its
    // HOLD_MAX-th consecutive grant cycle.
    assign w_force = (r_state == ST_GRANT) && w_owner_req && !done &&
                     (r_hold_cnt >= HOLD_MAX_C);

    // Hold counter: 1 in the first grant cycle, +1 per extra cycle held,
    // cleared on every release and while idle.
    always_comb begin
        w_hold_cnt_nxt = 8'd0;
        if ((r_state == ST_IDLE) && (req != 8'h00)) begin
            w_hold_cnt_nxt = 8'd1;
        end else if ((r_state == ST_GRANT) && !w_release) begin
            w_hold_cnt_nxt = r_hold_cnt + 8'd1;
        end else begin
            w_hold_cnt_nxt = 8'd0;
        end
    end

    // Hold counter and timeout pulse registers. The pulse lines up with the
    // cycle in which enb drops after a forced release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= 8'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_hold_cnt <= w_hold_cnt_nxt;
            r_timeout  <= w_force;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_force = 1'b0;
    assign timeout = 1'b0;
`endif

    assign w_release = !w_owner_req || done || w_force;

    // Next-state and next-output logic. Requests from other requesters are
    // ignored while a grant is active, so the owner cannot be preempted.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_enb_nxt   = 1'b0;
        w_gnt_nxt   = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (req != 8'h00) begin
                    w_state_nxt = ST_GRANT;
                    w_sel_nxt   = w_pick;
                    w_enb_nxt   = 1'b1;
                    w_gnt_nxt   = dec3to8(w_pick);
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_enb_nxt   = 1'b0;
                    w_gnt_nxt   = 8'h00;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    // done wins over a still-high request; the released owner
                    // becomes lowest priority because ptr moves past it.
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = r_sel + 3'd1;
                    w_enb_nxt   = 1'b0;
                    w_gnt_nxt   = 8'h00;
                end else begin
                    w_state_nxt = ST_GRANT;
                    w_enb_nxt   = 1'b1;
                    w_gnt_nxt   = dec3to8(r_sel);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = 3'd0;
                w_enb_nxt   = 1'b0;
                w_gnt_nxt   = 8'h00;
            end
        endcase
    end

    // State and output registers. The reset is asynchronous, so gnt drops as
    // soon as rst_n falls, even in the middle of a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= 3'd0;
            r_sel   <= 3'd0;
            r_enb   <= 1'b0;
            r_gnt   <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_enb   <= w_enb_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    assign enb = r_enb;
    assign sel = r_sel;
    assign gnt = r_gnt;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Testbench for decoder_rr_arbiter in its default build (timeout feature off).
// A behavioural model tracks the owner and the search pointer. One process
// compares the DUT against the model on every falling clock edge. Directed
// sequences also pin literal gnt values taken from the specification.
module tb_decoder_rr_arbiter;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req   = 8'hFF;
    logic       done  = 1'b0;
    logic       enb;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: is someone granted, who owns or last owned, and where the
    // next search starts.
    logic       m_vld = 1'b0;
    logic [2:0] m_sel = 3'd0;
    int         m_ptr = 0;

    decoder_rr_arbiter #(.HOLD_MAX(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .enb     (enb),
        .sel     (sel),
        .gnt     (gnt),
        .timeout (timeout)
    );

    // Clock with a 10-unit period.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [7:0] r, input int p);
        for (int i = 0; i < 8; i++) begin
            if (r[(p + i) % 8]) return (p + i) % 8;
        end
        return 0;
    endfunction

    // Behavioural model: the owner keeps the grant until it drops its request
    // or pulses done. After that there is one idle cycle, and the next search
    // starts just past the old owner.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld <= 1'b0;
            m_sel <= 3'd0;
            m_ptr <= 0;
        end else if (m_vld) begin
            if (!req[m_sel] || done) begin
                m_vld <= 1'b0;
                m_ptr <= (m_sel + 1) % 8;
            end
        end else if (req != 8'h00) begin
            m_vld <= 1'b1;
            m_sel <= 3'(first_from(req, m_ptr));
        end
    end

    // Compare the DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        check("cmp_enb", {7'd0, enb}, {7'd0, m_vld});
        check("cmp_sel", {5'd0, sel}, {5'd0, m_sel});
        check("cmp_gnt", gnt, m_vld ? (8'h01 << m_sel) : 8'h00);
        check("cmp_timeout", {7'd0, timeout}, 8'h00);
    end

    // Stop the run if it overruns its time budget.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        // Reset held with every requester asking.
        repeat (2) @(negedge clk);
        check("rst_enb", {7'd0, enb}, 8'h00);
        check("rst_gnt", gnt, 8'h00);
        check("rst_sel", {5'd0, sel}, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_first_gnt", gnt, 8'h01);

        // Round robin: done in the third grant cycle, one dead cycle between owners.
        for (int k = 0; k < 9; k++) begin
            check("rr_c1", gnt, 8'h01 << (k % 8));
            @(negedge clk);
            check("rr_c2", gnt, 8'h01 << (k % 8));
            @(negedge clk);
            check("rr_c3", gnt, 8'h01 << (k % 8));
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            check("rr_dead", gnt, 8'h00);
            @(negedge clk);
        end
        // Owner 1 holds now. Move the grant to 5 so the pointer lands on 6.
        check("rr_owner1", gnt, 8'h02);
        req = 8'h20;
        @(negedge clk);
        check("mv5_dead", gnt, 8'h00);
        @(negedge clk);
        check("mv5_gnt", gnt, 8'h20);
        done = 1'b1;
        req  = 8'h05;
        @(negedge clk);
        done = 1'b0;
        check("wrap_dead", gnt, 8'h00);
        @(negedge clk);
        check("wrap_gnt", gnt, 8'h01);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("skip_dead", gnt, 8'h00);
        @(negedge clk);
        check("skip_gnt", gnt, 8'h04);

        // No preemption: owner 3 keeps the grant while req[0] is also raised.
        req = 8'h08;
        @(negedge clk);
        check("np_dead0", gnt, 8'h00);
        @(negedge clk);
        check("np_own3", gnt, 8'h08);
        req = 8'h09;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("np_hold", gnt, 8'h08);
        end
        req = 8'h01;
        @(negedge clk);
        check("np_dead1", gnt, 8'h00);
        @(negedge clk);
        check("np_gnt0", gnt, 8'h01);

        // Asynchronous reset in the middle of a grant to requester 5.
        req = 8'h20;
        @(negedge clk);
        check("ar_dead", gnt, 8'h00);
        @(negedge clk);
        check("ar_gnt5", gnt, 8'h20);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_gnt_drop", gnt, 8'h00);
        check("ar_enb_drop", {7'd0, enb}, 8'h00);
        check("ar_sel_drop", {5'd0, sel}, 8'h00);

        // After reset the search restarts at 0 (a search from 1 would pick 7).
        @(negedge clk);
        req   = 8'h81;
        rst_n = 1'b1;
        @(negedge clk);
        check("ar_from0", gnt, 8'h01);

        // done wins over a still-high request, and requester 0 becomes lowest priority.
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("dw_dead", gnt, 8'h00);
        @(negedge clk);
        check("dw_gnt7", gnt, 8'h80);

        // Idle with no requests: enb low, sel keeps the last owner.
        req = 8'h00;
        @(negedge clk);
        check("idle_gnt", gnt, 8'h00);
        @(negedge clk);
        check("idle_sel", {5'd0, sel}, 8'h07);
        check("idle_enb", {7'd0, enb}, 8'h00);

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
